// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with frame-level debounce; accepted digits shift into
// a 32-bit display value, newest digit in the low nibble.
module hex_keypad_entry #(
    parameter int SCAN_LIMIT     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cols,
    input  logic        clear,
    output logic [3:0]  rows,
    output logic [31:0] number,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [3:0]  digit_count
);

    localparam int                 DWELL_W    = (SCAN_LIMIT > 1) ? $clog2(SCAN_LIMIT) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_LIMIT - 1);
    localparam logic [3:0]         STABLE_MAX = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0]         DIGITS_MAX = 4'd8;

    logic [3:0]         cols_meta_q, cols_meta_d;
    logic [3:0]         cols_sync_q, cols_sync_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         row_idx_q, row_idx_d;
    logic               scan_hit_q, scan_hit_d;
    logic [3:0]         scan_pos_q, scan_pos_d;
    logic               prev_hit_q, prev_hit_d;
    logic [3:0]         prev_pos_q, prev_pos_d;
    logic [3:0]         stable_q, stable_d;
    logic               armed_q, armed_d;
    logic [31:0]        number_q, number_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic [3:0]         digit_count_q, digit_count_d;

    logic       sample;
    logic       frame_end;
    logic       row_hit;
    logic [3:0] row_pos;
    logic       same_result;
    logic       accept;
    logic [3:0] key_value;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? max : v + 4'd1;
    endfunction

    // Lowest closed column wins within a row.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] key_of(input logic [3:0] pos);
        case (pos)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'hE;
            4'd13:   return 4'h0;
            4'd14:   return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    always_comb begin
        sample    = (dwell_q == DWELL_LAST);
        frame_end = sample && (row_idx_q == 2'd3);
        row_hit   = (cols_sync_q != 4'hF);
        row_pos   = {row_idx_q, first_low(cols_sync_q)};

        cols_meta_d = cols;
        cols_sync_d = cols_meta_q;
        dwell_d     = sample ? '0 : dwell_q + DWELL_W'(1);
        row_idx_d   = row_idx_q;
        if (sample) begin
            row_idx_d = (row_idx_q == 2'd3) ? 2'd0 : row_idx_q + 2'd1;
        end

        // Row 0 starts a new frame; later rows only fill in if nothing was found yet.
        scan_hit_d = scan_hit_q;
        scan_pos_d = scan_pos_q;
        if (sample) begin
            if (row_idx_q == 2'd0) begin
                scan_hit_d = row_hit;
                scan_pos_d = row_hit ? row_pos : 4'd0;
            end else if (!scan_hit_q && row_hit) begin
                scan_hit_d = 1'b1;
                scan_pos_d = row_pos;
            end
        end

        same_result = (scan_hit_d == prev_hit_q) && (scan_pos_d == prev_pos_q);
        key_value   = key_of(scan_pos_d);
        prev_hit_d  = prev_hit_q;
        prev_pos_d  = prev_pos_q;
        stable_d    = stable_q;
        armed_d     = armed_q;
        accept      = 1'b0;
        if (frame_end) begin
            stable_d   = same_result ? sat_inc(stable_q, STABLE_MAX) : 4'd1;
            prev_hit_d = scan_hit_d;
            prev_pos_d = scan_pos_d;
            if (stable_d == STABLE_MAX) begin
                if (scan_hit_d && armed_q) begin
                    accept  = 1'b1;
                    armed_d = 1'b0;
                end else if (!scan_hit_d) begin
                    armed_d = 1'b1;
                end
            end
        end

        // clear overrides a coincident accept; the key is dropped but stays disarmed.
        key_valid_d   = accept && !clear;
        number_d      = number_q;
        key_code_d    = key_code_q;
        digit_count_d = digit_count_q;
        if (clear) begin
            number_d      = 32'd0;
            digit_count_d = 4'd0;
        end else if (accept) begin
            number_d      = {number_q[27:0], key_value};
            key_code_d    = key_value;
            digit_count_d = sat_inc(digit_count_q, DIGITS_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_meta_q   <= 4'hF;
            cols_sync_q   <= 4'hF;
            dwell_q       <= '0;
            row_idx_q     <= 2'd0;
            scan_hit_q    <= 1'b0;
            scan_pos_q    <= 4'd0;
            prev_hit_q    <= 1'b0;
            prev_pos_q    <= 4'd0;
            stable_q      <= 4'd0;
            armed_q       <= 1'b1;
            number_q      <= 32'd0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            digit_count_q <= 4'd0;
        end else begin
            cols_meta_q   <= cols_meta_d;
            cols_sync_q   <= cols_sync_d;
            dwell_q       <= dwell_d;
            row_idx_q     <= row_idx_d;
            scan_hit_q    <= scan_hit_d;
            scan_pos_q    <= scan_pos_d;
            prev_hit_q    <= prev_hit_d;
            prev_pos_q    <= prev_pos_d;
            stable_q      <= stable_d;
            armed_q       <= armed_d;
            number_q      <= number_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign rows        = ~(4'b0001 << row_idx_q);
    assign number      = number_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign digit_count = digit_count_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: a keypad model drives cols from rows, and a
// frame-level reference model predicts every output cycle by cycle.
module tb_hex_keypad_entry;

    localparam int SL = 4;
    localparam int DB = 3;
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [31:0] number;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  digit_count;
    logic [15:0] pressed = 16'd0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_number;
    logic [3:0]  m_code;
    logic [3:0]  m_dc;
    bit          m_armed;
    bit          m_kv;
    int          hist[$];

    always #5 clk = ~clk;

    hex_keypad_entry #(.SCAN_LIMIT(SL), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .reset(reset), .cols(cols), .clear(clear), .rows(rows),
        .number(number), .key_code(key_code), .key_valid(key_valid), .digit_count(digit_count)
    );

    // Key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_result(input logic [15:0] m);
        for (int i = 0; i < 16; i++)
            if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_number = 32'd0;
        m_code   = 4'd0;
        m_dc     = 4'd0;
        m_armed  = 1'b1;
        m_kv     = 1'b0;
        hist.delete();
    endtask

    task automatic check_outputs(input int k);
        logic [3:0] er;
        er = ~(4'b0001 << (k / 4));
        chk("rows", 32'(rows), 32'(er));
        chk("key_valid", 32'(key_valid), 32'(m_kv));
        chk("number", number, m_number);
        chk("key_code", 32'(key_code), 32'(m_code));
        chk("digit_count", 32'(digit_count), 32'(m_dc));
    endtask

    // One 16-cycle frame with a fixed pressed set; optional clear or reset at cycle k.
    task automatic run_frame(input logic [15:0] mask, input int clear_at, input int rst_at);
        int  res;
        bit  stable;
        bit  accept;
        pressed = mask;
        for (int k = 0; k < 16; k++) begin
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_outputs(0);
                #1;
                reset = 1'b1;
                return;
            end
            check_outputs(k);
            if (k == 0) m_kv = 1'b0;
            clear = (k == clear_at);
            @(posedge clk);
            #1;
            clear = 1'b0;
            if (k == clear_at && k < 15) begin
                m_number = 32'd0;
                m_dc     = 4'd0;
            end
        end
        res = frame_result(mask);
        hist.push_back(res);
        if (hist.size() > DB) void'(hist.pop_front());
        stable = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != res) stable = 1'b0;
        accept = stable && (res >= 0) && m_armed;
        if (accept) m_armed = 1'b0;
        if (stable && res < 0) m_armed = 1'b1;
        if (clear_at == 15) begin
            m_number = 32'd0;
            m_dc     = 4'd0;
        end else if (accept) begin
            m_kv     = 1'b1;
            m_code   = KEYMAP[res];
            m_number = {m_number[27:0], KEYMAP[res]};
            m_dc     = (m_dc < 4'd8) ? m_dc + 4'd1 : 4'd8;
        end
    endtask

    localparam logic [15:0] K1 = 16'd1 << 0;
    localparam logic [15:0] K2 = 16'd1 << 1;
    localparam logic [15:0] K5 = 16'd1 << 5;
    localparam logic [15:0] K7 = 16'd1 << 8;
    localparam logic [15:0] K9 = 16'd1 << 10;
    localparam int SEQ [9] = '{0, 1, 2, 3, 7, 11, 15, 12, 14};

    initial begin
        logic [15:0] mask;
        int p;
        int ca;
        int ra;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs(0);
        reset = 1'b1;

        // Idle scanning
        repeat (4) run_frame(16'd0, -1, -1);
        chk("idle_number", number, 32'd0);

        // Single held key "5"
        for (int f = 0; f < 5; f++) begin
            run_frame(K5, -1, -1);
            if (f == 2) begin
                chk("k5_valid", 32'(key_valid), 32'd1);
                chk("k5_code", 32'(key_code), 32'h5);
            end
        end
        repeat (4) run_frame(16'd0, -1, -1);
        chk("k5_number", number, 32'h5);
        chk("k5_count", 32'(digit_count), 32'd1);

        // Nine-key entry with overflow of the oldest digit
        run_frame(16'd0, 7, -1);
        for (int i = 0; i < 9; i++) begin
            repeat (DB) run_frame(16'd1 << SEQ[i], -1, -1);
            if (i == 7) chk("eight_digits", number, 32'h123ABCDE);
            repeat (DB) run_frame(16'd0, -1, -1);
        end
        chk("nine_digits", number, 32'h23ABCDEF);
        chk("nine_count", 32'(digit_count), 32'd8);

        // Bouncing key then a clean hold
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? K1 : 16'd0, -1, -1);
        repeat (DB) run_frame(K1, -1, -1);
        chk("bounce_valid", 32'(key_valid), 32'd1);
        chk("bounce_code", 32'(key_code), 32'h1);
        repeat (DB) run_frame(16'd0, -1, -1);

        // Two keys at once, then roll to the other without release
        repeat (DB) run_frame(K1 | K9, -1, -1);
        chk("multi_code", 32'(key_code), 32'h1);
        repeat (4) run_frame(K9, -1, -1);
        chk("roll_no_valid", 32'(key_valid), 32'd0);
        chk("roll_code", 32'(key_code), 32'h1);
        repeat (DB) run_frame(16'd0, -1, -1);
        repeat (DB) run_frame(K9, -1, -1);
        chk("rearm_code", 32'(key_code), 32'h9);
        repeat (DB) run_frame(16'd0, -1, -1);

        // Clear coinciding with an accept, then reset mid-frame with a key held
        repeat (DB - 1) run_frame(K2, -1, -1);
        run_frame(K2, 15, -1);
        chk("clr_valid", 32'(key_valid), 32'd0);
        chk("clr_number", number, 32'd0);
        chk("clr_count", 32'(digit_count), 32'd0);
        repeat (DB) run_frame(16'd0, -1, -1);
        run_frame(K7, -1, 6);
        repeat (DB + 2) run_frame(K7, -1, -1);
        repeat (DB) run_frame(16'd0, -1, -1);

        // Randomized key activity
        mask = 16'd0;
        for (int f = 0; f < 80; f++) begin
            p = $urandom_range(0, 99);
            if (p >= 45 && p < 70)      mask = 16'd0;
            else if (p >= 70 && p < 88) mask = 16'd1 << $urandom_range(0, 15);
            else if (p >= 88)           mask = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            p = $urandom_range(0, 99);
            ca = (p < 8) ? 15 : ((p < 14) ? $urandom_range(0, 14) : -1);
            ra = ($urandom_range(0, 99) < 3) ? $urandom_range(0, 15) : -1;
            run_frame(mask, ca, ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
